frame_swap_controller: RTL and testbench

Double-buffer sequencer for the two 320x... 640x480 5-bit encoded frame banks (Top/Bottom) read by the VGA pixel path.
- Owns which bank is front (displayed) and which is back (drawn).
- Clears the back bank to a background colour, then grants the sprite renderer exclusive write access.
- Swaps banks only at the falling edge of VS, so the display never shows a half-drawn frame.

---
 rtl/fb_pkg.sv | 17 +
 rtl/vsync_edge_detect.sv | 21 ++
 rtl/frame_swap_controller.sv | 133 +++++++++++++
 tb/tb_frame_swap_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-bank double-buffer logic.
package fb_pkg;

    localparam int unsigned FRAME_PIXELS = 307200;
    localparam int unsigned ADDR_W       = 19;
    localparam int unsigned PIX_W        = 5;

    typedef enum logic [1:0] {
        CLEAR,
        DRAW,
        WAIT_SWAP
    } fb_state_t;

    localparam logic [1:0] GS_START = 2'b00;
    localparam logic [1:0] GS_PLAY  = 2'b01;

endpackage

// File: rtl/vsync_edge_detect.sv
// Flags the falling edge of the active-low vertical sync (same clock domain).
module vsync_edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic VS,
    output logic vs_fall
);

    logic vs_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_q <= 1'b1;
        end else begin
            vs_q <= VS;
        end
    end

    assign vs_fall = vs_q & ~VS;

endmodule

// File: rtl/frame_swap_controller.sv
// Double-buffer sequencer: clears the back bank, hands it to the renderer,
// and swaps front/back only on a VS falling edge.
module frame_swap_controller #(
    parameter int unsigned FRAME_PIXELS = fb_pkg::FRAME_PIXELS,
    parameter int unsigned ADDR_W       = fb_pkg::ADDR_W,
    parameter int unsigned PIX_W        = fb_pkg::PIX_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              VS,
    input  logic [1:0]        gameState,
    input  logic [PIX_W-1:0]  clear_color,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [PIX_W-1:0]  draw_data,
    input  logic              frame_done,
    output logic              draw_ack,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              front_sel,
    output logic              swap_pulse,
    output logic [15:0]       frame_count,
    output logic              ready
);

    import fb_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    fb_state_t         state_q,     state_d;
    logic [ADDR_W-1:0] clr_addr_q,  clr_addr_d;
    logic              wr_en_q,     wr_en_d;
    logic              wr_sel_q,    wr_sel_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q,   wr_data_d;
    logic              front_q,     front_d;
    logic              swap_q,      swap_d;
    logic [15:0]       count_q,     count_d;
    logic              vs_fall;

    vsync_edge_detect u_vs_edge (
        .Clk     (Clk),
        .Reset   (Reset),
        .VS      (VS),
        .vs_fall (vs_fall)
    );

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_en_d    = 1'b0;
        wr_sel_d   = wr_sel_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        front_d    = front_q;
        swap_d     = 1'b0;
        count_d    = count_q;

        case (state_q)
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_addr_q;
                wr_data_d = clear_color;
                if (clr_addr_q == LAST_ADDR) begin
                    clr_addr_d = '0;
                    state_d    = DRAW;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            DRAW: begin
                if (draw_req) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = draw_addr;
                    wr_data_d = draw_data;
                end
                if (frame_done) begin
                    state_d = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                // Old front becomes the new back, so wr_sel takes its value.
                if (vs_fall) begin
                    front_d  = ~front_q;
                    wr_sel_d = front_q;
                    swap_d   = 1'b1;
                    count_d  = count_q + 16'd1;
                    state_d  = (gameState == GS_PLAY) ? CLEAR : DRAW;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= 1'b1;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            front_q    <= 1'b0;
            swap_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wr_en_q    <= wr_en_d;
            wr_sel_q   <= wr_sel_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            front_q    <= front_d;
            swap_q     <= swap_d;
            count_q    <= count_d;
        end
    end

    assign draw_ack    = (state_q == DRAW) & draw_req;
    assign ready       = (state_q == DRAW);
    assign wr_en       = wr_en_q;
    assign wr_sel      = wr_sel_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign front_sel   = front_q;
    assign swap_pulse  = swap_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_frame_swap_controller.sv
// Scoreboarded bench for frame_swap_controller with a 16-pixel bank.
module tb_frame_swap_controller;

    localparam int unsigned NPIX = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        VS;
    logic [1:0]  gameState;
    logic [4:0]  clear_color;
    logic        draw_req;
    logic [18:0] draw_addr;
    logic [4:0]  draw_data;
    logic        frame_done;
    logic        draw_ack;
    logic        wr_en;
    logic        wr_sel;
    logic [18:0] wr_addr;
    logic [4:0]  wr_data;
    logic        front_sel;
    logic        swap_pulse;
    logic [15:0] frame_count;
    logic        ready;

    typedef struct {
        logic        sel;
        logic [18:0] addr;
        logic [4:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int unsigned checks = 0;
    int unsigned failures = 0;

    frame_swap_controller #(.FRAME_PIXELS(NPIX)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .VS          (VS),
        .gameState   (gameState),
        .clear_color (clear_color),
        .draw_req    (draw_req),
        .draw_addr   (draw_addr),
        .draw_data   (draw_data),
        .frame_done  (frame_done),
        .draw_ack    (draw_ack),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .front_sel   (front_sel),
        .swap_pulse  (swap_pulse),
        .frame_count (frame_count),
        .ready       (ready)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_wr(input logic sel, input logic [18:0] addr, input logic [4:0] data);
        wr_t e;
        e.sel  = sel;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Every registered bank write must match the next expected entry.
    initial begin
        wr_t e;
        forever begin
            @(negedge Clk);
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexp_wr", {13'd0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_sel",  {31'd0, wr_sel}, {31'd0, e.sel});
                    check("wr_addr", {13'd0, wr_addr}, {13'd0, e.addr});
                    check("wr_data", {27'd0, wr_data}, {27'd0, e.data});
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},  {31'd0, wr_en}, 32'd0);
        check({tag, "_wr_sel"}, {31'd0, wr_sel}, 32'd1);
        check({tag, "_addr"},   {13'd0, wr_addr}, 32'd0);
        check({tag, "_data"},   {27'd0, wr_data}, 32'd0);
        check({tag, "_front"},  {31'd0, front_sel}, 32'd0);
        check({tag, "_swap"},   {31'd0, swap_pulse}, 32'd0);
        check({tag, "_count"},  {16'd0, frame_count}, 32'd0);
        check({tag, "_ready"},  {31'd0, ready}, 32'd0);
    endtask

    initial begin
        logic [18:0] a;
        logic [4:0]  d;

        Reset = 1'b1; VS = 1'b1; gameState = 2'b01; clear_color = 5'h0A;
        draw_req = 1'b0; draw_addr = '0; draw_data = '0; frame_done = 1'b0;
        #12;
        check_reset_outputs("rst");

        // Initial clear of bank 1.
        for (int i = 0; i < NPIX; i++) push_wr(1'b1, 19'(i), 5'h0A);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            tick();
            if (i < NPIX - 1) check("clr_ready_lo", {31'd0, ready}, 32'd0);
        end
        tick();
        check("ready_after_clr", {31'd0, ready}, 32'd1);
        check("idle_wr_en", {31'd0, wr_en}, 32'd0);
        check("clr_drained", exp_q.size(), 32'd0);

        // Draw writes, including one coincident with frame_done.
        draw_req = 1'b1; draw_addr = 19'h00005; draw_data = 5'h13;
        push_wr(1'b1, 19'h00005, 5'h13);
        #1 check("ack_draw", {31'd0, draw_ack}, 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            a = 19'($urandom);
            d = 5'($urandom);
            draw_addr = a; draw_data = d;
            push_wr(1'b1, a, d);
            #1 check("ack_rand", {31'd0, draw_ack}, 32'd1);
            tick();
        end
        draw_addr = 19'h7FFFF; draw_data = 5'h1F; frame_done = 1'b1;
        push_wr(1'b1, 19'h7FFFF, 5'h1F);
        #1 check("ack_with_done", {31'd0, draw_ack}, 32'd1);
        tick();
        frame_done = 1'b0;
        #1 check("ack_in_wait", {31'd0, draw_ack}, 32'd0);
        check("ready_in_wait", {31'd0, ready}, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        draw_req = 1'b0;

        // First swap in play mode, then clear bank 0 with a mid-clear colour change.
        VS = 1'b0;
        tick();
        check("swap1_pulse", {31'd0, swap_pulse}, 32'd1);
        check("swap1_front", {31'd0, front_sel}, 32'd1);
        check("swap1_wrsel", {31'd0, wr_sel}, 32'd0);
        check("swap1_count", {16'd0, frame_count}, 32'd1);
        VS = 1'b1;
        for (int k = 0; k < NPIX; k++) begin
            clear_color = (k < 8) ? 5'h0A : 5'h15;
            push_wr(1'b0, 19'(k), clear_color);
            tick();
            check("swap1_pulse_once", {31'd0, swap_pulse}, 32'd0);
        end
        tick();
        check("ready_after_clr2", {31'd0, ready}, 32'd1);
        check("clr2_drained", exp_q.size(), 32'd0);

        // frame_done coincident with a VS fall must not swap.
        frame_done = 1'b1; VS = 1'b0;
        tick();
        frame_done = 1'b0; VS = 1'b1;
        check("coinc_no_swap", {31'd0, swap_pulse}, 32'd0);
        check("coinc_front", {31'd0, front_sel}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("coinc_wait", {31'd0, swap_pulse}, 32'd0);
        end

        // Start-screen swap: no clear, straight back to DRAW.
        gameState = 2'b00; VS = 1'b0;
        tick();
        VS = 1'b1;
        check("swap2_pulse", {31'd0, swap_pulse}, 32'd1);
        check("swap2_front", {31'd0, front_sel}, 32'd0);
        check("swap2_wrsel", {31'd0, wr_sel}, 32'd1);
        check("swap2_count", {16'd0, frame_count}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("gs0_ready", {31'd0, ready}, 32'd1);
            check("gs0_no_wr", {31'd0, wr_en}, 32'd0);
        end

        // Play-mode swap, then reset in the middle of the clear.
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        gameState = 2'b01; VS = 1'b0; clear_color = 5'h07;
        tick();
        VS = 1'b1;
        check("swap3_front", {31'd0, front_sel}, 32'd1);
        check("swap3_count", {16'd0, frame_count}, 32'd3);
        for (int k = 0; k < 8; k++) begin
            push_wr(1'b0, 19'(k), 5'h07);
            tick();
        end
        check("clr_at7", {13'd0, wr_addr}, 32'd7);
        @(negedge Clk);
        #1 Reset = 1'b1;
        #1 check_reset_outputs("midrst");
        check("midrst_drained", exp_q.size(), 32'd0);

        for (int i = 0; i < NPIX; i++) push_wr(1'b1, 19'(i), 5'h07);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < NPIX + 2; i++) tick();
        check("rst_clr_ready", {31'd0, ready}, 32'd1);
        check("rst_clr_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
